// File: rtl/dark_channel_prior_if.sv
// Video stream bundle carrying frame/line syncs, the pixel strobe, RGB and
// the filtered dark-channel value between imaging stages.
interface dark_channel_prior_if;
  logic       vsync;
  logic       href;
  logic       clken;
  logic [7:0] img_R;
  logic [7:0] img_G;
  logic [7:0] img_B;
  logic [7:0] img_Dark;

  modport master (output vsync, href, clken, img_R, img_G, img_B, img_Dark);
  modport slave  (input  vsync, href, clken, img_R, img_G, img_B);
endinterface

// File: rtl/dark_channel_prior.sv
// Dark channel prior: trailing 3x3 minimum of min(R,G,B) with a 3-clk pipeline,
// plus a per-frame atmospheric-light estimate (max dark value, never below 1).
module dark_channel_prior #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dark_channel_prior_if.slave         per_frame,
  dark_channel_prior_if.master        post_frame,
  output logic [7:0]                  atmospheric_light
);

  localparam int XW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  logic          r_armed;
  logic          w_vsync;
  logic          w_href;
  logic          w_valid;
  logic [7:0]    w_pixMin;

  // After reset, ignore a frame already in flight until vsync has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_armed <= 1'b0;
    else if (!per_frame.vsync)
      r_armed <= 1'b1;
  end

  assign w_vsync  = per_frame.vsync & r_armed;
  assign w_href   = per_frame.href & w_vsync;
  assign w_valid  = per_frame.clken & w_href;
  assign w_pixMin = min3(per_frame.img_R, per_frame.img_G, per_frame.img_B);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_hrefPrev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_hrefPrev <= 1'b0;
    end else begin
      r_hrefPrev <= w_href;
      if (!w_href)
        r_x <= '0;
      else if (w_valid && (r_x != X_LAST))
        r_x <= r_x + 1'b1;
      if (!w_vsync)
        r_y <= '0;
      else if (r_hrefPrev && !w_href && (r_y != Y_LAST))
        r_y <= r_y + 1'b1;
    end
  end

  logic [7:0] r_line1 [IMG_HDISP];
  logic [7:0] r_line2 [IMG_HDISP];
  logic [7:0] r_tap0, r_tap1, r_tap2;
  logic       r_xLt1, r_xLt2;
  logic [7:0] r_R1, r_G1, r_B1;

  // Stage 1: read rows y-1/y-2 at this column while writing row y; rows above
  // the frame top read as 255 so they never win the minimum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_HDISP; i++) begin
        r_line1[i] <= '0;
        r_line2[i] <= '0;
      end
      r_tap0 <= '0;
      r_tap1 <= '0;
      r_tap2 <= '0;
      r_xLt1 <= 1'b0;
      r_xLt2 <= 1'b0;
      r_R1   <= '0;
      r_G1   <= '0;
      r_B1   <= '0;
    end else if (w_valid) begin
      r_line1[r_x] <= w_pixMin;
      r_line2[r_x] <= r_line1[r_x];
      r_tap0       <= w_pixMin;
      r_tap1       <= (r_y == '0) ? 8'd255 : r_line1[r_x];
      r_tap2       <= ((r_y == '0) || (r_y == YW'(1))) ? 8'd255 : r_line2[r_x];
      r_xLt1       <= (r_x == '0);
      r_xLt2       <= (r_x == '0) || (r_x == XW'(1));
      r_R1         <= per_frame.img_R;
      r_G1         <= per_frame.img_G;
      r_B1         <= per_frame.img_B;
    end
  end

  logic [2:0] r_vsDly, r_hsDly, r_ceDly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsDly <= '0;
      r_hsDly <= '0;
      r_ceDly <= '0;
    end else begin
      r_vsDly <= {r_vsDly[1:0], w_vsync};
      r_hsDly <= {r_hsDly[1:0], w_href};
      r_ceDly <= {r_ceDly[1:0], w_valid};
    end
  end

  logic [7:0] r_col0, r_col1, r_col2;
  logic [7:0] r_R2, r_G2, r_B2;

  // Stage 2: column minimum enters the 3-deep column shift; columns left of
  // the line start are forced to 255 instead of carrying the previous line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col0 <= '0;
      r_col1 <= '0;
      r_col2 <= '0;
      r_R2   <= '0;
      r_G2   <= '0;
      r_B2   <= '0;
    end else if (r_ceDly[0]) begin
      r_col0 <= min3(r_tap0, r_tap1, r_tap2);
      r_col1 <= r_xLt1 ? 8'd255 : r_col0;
      r_col2 <= r_xLt2 ? 8'd255 : r_col1;
      r_R2   <= r_R1;
      r_G2   <= r_G1;
      r_B2   <= r_B1;
    end
  end

  logic [7:0] r_dark;
  logic [7:0] r_R3, r_G3, r_B3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dark <= '0;
      r_R3   <= '0;
      r_G3   <= '0;
      r_B3   <= '0;
    end else if (r_ceDly[1]) begin
      r_dark <= min3(r_col0, r_col1, r_col2);
      r_R3   <= r_R2;
      r_G3   <= r_G2;
      r_B3   <= r_B2;
    end
  end

  logic       r_vsPostPrev;
  logic       w_postRise;
  logic       w_postFall;
  logic [7:0] r_frameMax;
  logic [7:0] r_atmos;

  assign w_postRise = r_vsDly[2] & ~r_vsPostPrev;
  assign w_postFall = ~r_vsDly[2] & r_vsPostPrev;

  // Frame max tracks the output stream; A is floored at 1 so a divide by A
  // downstream can never see zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsPostPrev <= 1'b0;
      r_frameMax   <= '0;
      r_atmos      <= 8'd255;
    end else begin
      r_vsPostPrev <= r_vsDly[2];
      if (w_postRise)
        r_frameMax <= r_ceDly[2] ? r_dark : 8'd0;
      else if (r_ceDly[2] && (r_dark > r_frameMax))
        r_frameMax <= r_dark;
      if (w_postFall)
        r_atmos <= (r_frameMax == '0) ? 8'd1 : r_frameMax;
    end
  end

  assign post_frame.vsync    = r_vsDly[2];
  assign post_frame.href     = r_hsDly[2];
  assign post_frame.clken    = r_ceDly[2];
  assign post_frame.img_R    = r_R3;
  assign post_frame.img_G    = r_G3;
  assign post_frame.img_B    = r_B3;
  assign post_frame.img_Dark = r_dark;
  assign atmospheric_light   = r_atmos;

endmodule

// File: tb/tb_dark_channel_prior.sv
// Directed bench for dark_channel_prior on an 8x4 frame: uniform, single-pixel,
// gapped-strobe, all-zero, two-frame A update and mid-line reset scenarios.
module tb_dark_channel_prior;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] atmosLight;

  dark_channel_prior_if perFrame();
  dark_channel_prior_if postFrame();

  dark_channel_prior #(.IMG_HDISP(W), .IMG_VDISP(H)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .per_frame         (perFrame),
    .post_frame        (postFrame),
    .atmospheric_light (atmosLight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  logic [7:0] pixR    [H][W];
  logic [7:0] pixG    [H][W];
  logic [7:0] pixB    [H][W];
  logic [7:0] expDark [H][W];
  int         inQ[$];
  int         outCount = 0;
  bit         monEn = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Output stream monitor; a pixel sampled at edge s is visible after edge s+2.
  always @(negedge clk) begin
    if (monEn && (postFrame.clken === 1'b1)) begin
      int r;
      int c;
      int inEdge;
      r = outCount / W;
      c = outCount % W;
      if (outCount < W * H) begin
        checkOutput($sformatf("dark(%0d,%0d)", c, r), postFrame.img_Dark, expDark[r][c]);
        checkOutput($sformatf("red(%0d,%0d)", c, r), postFrame.img_R, pixR[r][c]);
      end
      checks++;
      assert (inQ.size() != 0) else begin
        errors++;
        $error("[TB] FAIL outputWithoutInput observed=%0d expected=0", outCount);
      end
      if (inQ.size() != 0) begin
        inEdge = inQ.pop_front();
        checkOutput($sformatf("latency(%0d,%0d)", c, r), edgeCount - inEdge, 2);
      end
      outCount++;
    end
  end

  task automatic fillUniform(input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic [7:0] dark);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        pixR[y][x]    = r;
        pixG[y][x]    = g;
        pixB[y][x]    = b;
        expDark[y][x] = dark;
      end
  endtask

  task automatic fillSinglePixel();
    fillUniform(8'd255, 8'd255, 8'd255, 8'd255);
    pixB[1][3] = 8'd10;
    for (int y = 1; y <= 3; y++)
      for (int x = 3; x <= 5; x++)
        expDark[y][x] = 8'd10;
  endtask

  task automatic applyStimulus(input bit gapped, input logic [7:0] aDuring);
    perFrame.vsync = 1'b1;
    repeat (3) @(negedge clk);
    for (int y = 0; y < H; y++) begin
      perFrame.href = 1'b1;
      for (int x = 0; x < W; x++) begin
        perFrame.clken = 1'b1;
        perFrame.img_R = pixR[y][x];
        perFrame.img_G = pixG[y][x];
        perFrame.img_B = pixB[y][x];
        inQ.push_back(edgeCount + 1);
        @(negedge clk);
        if (gapped) begin
          perFrame.clken = 1'b0;
          @(negedge clk);
        end
      end
      perFrame.clken = 1'b0;
      perFrame.href  = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput($sformatf("atmosLine%0d", y), atmosLight, aDuring);
    end
    perFrame.vsync = 1'b0;
    checkOutput("atmosAtVsyncFall", atmosLight, aDuring);
    repeat (8) @(negedge clk);
  endtask

  task automatic runFrame(input string name, input bit gapped,
                          input logic [7:0] aDuring, input logic [7:0] aAfter);
    outCount = 0;
    inQ.delete();
    monEn = 1'b1;
    applyStimulus(gapped, aDuring);
    checkOutput({name, ":pixelCount"}, outCount, W * H);
    checkOutput({name, ":atmosAfter"}, atmosLight, aAfter);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, ":vsync"}, postFrame.vsync, 0);
    checkOutput({name, ":href"},  postFrame.href, 0);
    checkOutput({name, ":clken"}, postFrame.clken, 0);
    checkOutput({name, ":R"},     postFrame.img_R, 0);
    checkOutput({name, ":G"},     postFrame.img_G, 0);
    checkOutput({name, ":B"},     postFrame.img_B, 0);
    checkOutput({name, ":dark"},  postFrame.img_Dark, 0);
    checkOutput({name, ":atmos"}, atmosLight, 255);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    perFrame.vsync    = 1'b0;
    perFrame.href     = 1'b0;
    perFrame.clken    = 1'b0;
    perFrame.img_R    = '0;
    perFrame.img_G    = '0;
    perFrame.img_B    = '0;
    perFrame.img_Dark = '0;

    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("powerOnReset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    fillUniform(8'd200, 8'd100, 8'd150, 8'd100);
    runFrame("uniform", 1'b0, 8'd255, 8'd100);

    fillSinglePixel();
    runFrame("singlePixel", 1'b0, 8'd100, 8'd255);
    runFrame("singlePixelGapped", 1'b1, 8'd255, 8'd255);

    fillUniform(8'd0, 8'd0, 8'd0, 8'd0);
    runFrame("allZero", 1'b0, 8'd255, 8'd1);

    fillUniform(8'd80, 8'd80, 8'd80, 8'd80);
    runFrame("max80", 1'b0, 8'd1, 8'd80);
    fillUniform(8'd120, 8'd120, 8'd120, 8'd120);
    runFrame("max120", 1'b0, 8'd80, 8'd120);

    // Partial line, then reset in the middle of it.
    monEn = 1'b0;
    fillUniform(8'd200, 8'd100, 8'd150, 8'd100);
    perFrame.vsync = 1'b1;
    repeat (3) @(negedge clk);
    perFrame.href = 1'b1;
    for (int x = 0; x < 3; x++) begin
      perFrame.clken = 1'b1;
      perFrame.img_R = 8'd200;
      perFrame.img_G = 8'd100;
      perFrame.img_B = 8'd150;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkResetState("midLineReset");
    perFrame.vsync = 1'b0;
    perFrame.href  = 1'b0;
    perFrame.clken = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("heldReset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    runFrame("afterReset", 1'b0, 8'd255, 8'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dark_channel_prior.md
DARK_CHANNEL_PRIOR -- requirements
Module: dark_channel_prior

Interface
REQ-001 Parameter IMG_HDISP, default 640, active pixels per line; sets line-buffer depth.
REQ-002 Parameter IMG_VDISP, default 480, active lines per frame; used only for row-counter saturation.
REQ-003 clk  input  1  pixel clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 per_frame_vsync  input  1  high for the whole active frame.
REQ-006 per_frame_href  input  1  high for each active line.
REQ-007 per_frame_clken  input  1  pixel-valid strobe, qualified by href.
REQ-008 per_img_R / per_img_G / per_img_B  input  8 each  input pixel.
REQ-009 post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  sync, delayed 3 clk.
REQ-010 post_img_R / post_img_G / post_img_B  output  8 each  input pixel, delayed 3 clk.
REQ-011 post_img_Dark  output  8  3x3 min-filtered dark channel.
REQ-012 atmospheric_light  output  8  per-frame estimate of A, stable for the whole following frame.

Function
REQ-013 Stage 1 (clk 1) SHALL compute pix_min = min(R,G,B) for each input sample.
REQ-014 Two line buffers (IMG_HDISP x 8 bit) SHALL advance only on per_frame_clken and SHALL supply pix_min at the same column for rows y-1 and y-2.
REQ-015 Column counter x SHALL count clken within href, starting at 0, and SHALL clear while href is low.
REQ-016 Row counter y SHALL increment on each href falling edge, SHALL clear while vsync is low, and SHALL saturate at IMG_VDISP-1.
REQ-017 Window positions with row < 0 or column < 0 (y<2 or x<2 for the respective taps) SHALL be substituted with 8'd255, so that they do not lower the minimum.
REQ-018 Stage 2 (clk 2) SHALL form col_min = min of the 3 row taps and shift it into a 3-deep column register, only when the stage-1 clken is high.
REQ-019 Stage 3 (clk 3) SHALL register post_img_Dark = min of the 3 column registers.
REQ-020 The window SHALL be trailing: for input pixel (x,y), post_img_Dark = min of pix_min over rows y-2..y and columns x-2..x.
REQ-021 Latency SHALL be exactly 3 clk from the input sample to post_img_Dark, RGB and sync outputs, independent of clken gaps.
REQ-022 Pipeline registers SHALL hold their value when clken is low; sync delay lines SHALL shift every clk.
REQ-023 Frame max register: cleared to 0 on vsync rising edge; on each post_frame_clken it SHALL become max(current, post_img_Dark).
REQ-024 On post_frame_vsync falling edge, atmospheric_light SHALL load max(frame_max, 1) so that downstream division by zero is impossible.
REQ-025 A vsync falling edge mid-line SHALL still latch atmospheric_light; counters SHALL reset and no line-buffer flush is required.

Reset
REQ-026 When rst_n is low, all outputs SHALL be 0 except atmospheric_light, which SHALL be 8'd255; counters, line buffers, column registers and frame_max SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL take effect immediately; the first frame after release SHALL be treated as a fresh frame from the next vsync rise.

Verification
REQ-028 Uniform frame with R=200, G=100, B=150 at 8x4 (IMG_HDISP=8) -> post_img_Dark=100 for every pixel; atmospheric_light=100 after vsync falls.
REQ-029 Single pixel B=10 at (3,1), all other channels 255 -> Dark=10 exactly at outputs (3..5, 1..3) and 255 elsewhere; A=255.
REQ-030 clken toggling every other clk -> output values identical to the continuous-clken run; each output appears 3 clk after its input sample.
REQ-031 All-zero frame -> atmospheric_light=1, not 0.
REQ-032 Reset pulse mid-line -> all outputs 0 and A=255 within the reset; the next full frame reproduces the golden output.
REQ-033 Two frames with max Dark 80 then 120 -> A=80 during frame 2 and changes to 120 only at frame-2 vsync fall.
